// File: rtl/tmr_vote_monitor.sv
// Majority voter for a triplicated bus with upset detection, saturating error count
// and an optional event FIFO (built only when TMR_EVENT_FIFO_EN is defined).
module tmr_vote_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH+1:0] evt_data,
    output logic             evt_drop
);

    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] mask;
    logic             mismatch;

    always_comb begin
        maj      = (inA & inB) | (inB & inC) | (inA & inC);
        mask     = (inA ^ inB) | (inB ^ inC);
        mismatch = |mask;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            out <= maj;
            err <= mismatch;
            if (clr)
                err_cnt <= '0;
            else if (mismatch && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef TMR_EVENT_FIFO_EN
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH+1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [1:0]       id;
    logic             push;
    logic             pop;
    logic             drop;

    // A single odd copy means the other two agree on the whole word.
    always_comb begin
        if (inB == inC)
            id = 2'd1;
        else if (inA == inC)
            id = 2'd2;
        else if (inA == inB)
            id = 2'd3;
        else
            id = 2'd0;
        pop  = (count != '0) && evt_ready;
        push = mismatch && ((count != FULL) || pop);
        drop = mismatch && !push;
    end

    always_ff @(posedge clk) begin
        if (rstn && push)
            mem[wr_ptr] <= {id, mask};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            evt_drop <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr)
                evt_drop <= 1'b0;
            else if (drop)
                evt_drop <= 1'b1;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
`else
    logic unused_ready;
    assign unused_ready = evt_ready;
    assign evt_valid    = 1'b0;
    assign evt_data     = '0;
    assign evt_drop     = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed vector table, multi-cycle FIFO corner cases and
// randomized traffic against a queue-based reference model (follows TMR_EVENT_FIFO_EN).
module tb_tmr_vote_monitor;

    localparam int W = 8;
    localparam int D = 4;
`ifdef TMR_EVENT_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn, clr, evt_ready;
    logic [W-1:0] a, b, c;

    logic [W-1:0] out, out4;
    logic         err, err4;
    logic [15:0]  cnt;
    logic [3:0]   cnt4;
    logic         valid, valid4, drop, drop4;
    logic [W+1:0] data, data4;

    always #5 clk = ~clk;

    tmr_vote_monitor #(.WIDTH(W), .CNT_W(16), .DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .inA(a), .inB(b), .inC(c), .clr(clr),
        .out(out), .err(err), .err_cnt(cnt), .evt_valid(valid),
        .evt_ready(evt_ready), .evt_data(data), .evt_drop(drop)
    );

    tmr_vote_monitor #(.WIDTH(W), .CNT_W(4), .DEPTH(D)) dut4 (
        .clk(clk), .rstn(rstn), .inA(a), .inB(b), .inC(c), .clr(clr),
        .out(out4), .err(err4), .err_cnt(cnt4), .evt_valid(valid4),
        .evt_ready(evt_ready), .evt_data(data4), .evt_drop(drop4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W+1:0] q[$];
    int           m_cnt, m_cnt4;
    bit           m_drop, m_err;
    logic [W-1:0] m_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] v, m;
        int ones, o, odd;
        bit first, mis, pop;
        v = '0; m = '0; odd = 0; first = 1'b1;
        for (int i = 0; i < W; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            v[i] = (ones >= 2);
            if (ones == 1 || ones == 2) begin
                m[i] = 1'b1;
                if (b[i] == c[i]) o = 1;
                else if (a[i] == c[i]) o = 2;
                else o = 3;
                if (first) begin odd = o; first = 1'b0; end
                else if (odd != o) odd = 0;
            end
        end
        mis = (m != '0);
        if (!rstn) begin
            q.delete();
            m_cnt = 0; m_cnt4 = 0; m_drop = 0; m_out = '0; m_err = 0;
        end else begin
            pop = FIFO_EN && (q.size() > 0) && evt_ready;
            if (pop) void'(q.pop_front());
            if (mis && FIFO_EN) begin
                if (q.size() < D) q.push_back({2'(odd), m});
                else m_drop = 1'b1;
            end
            if (clr) begin
                m_cnt = 0; m_cnt4 = 0; m_drop = 0;
            end else if (mis) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_out = v;
            m_err = mis;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("out", out, m_out);
        check("out4", out4, m_out);
        check("err", err, m_err);
        check("err_cnt", cnt, m_cnt);
        check("err_cnt4", cnt4, m_cnt4);
        check("evt_valid", valid, q.size() > 0);
        check("evt_data", data, (q.size() > 0) ? q[0] : 10'h0);
        check("evt_drop", drop, m_drop);
    endtask

    typedef struct {
        logic [W-1:0] a, b, c;
        logic [W-1:0] exp_out;
        bit           exp_err;
        logic [1:0]   exp_id;
        logic [W-1:0] exp_mask;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] base;
        int n_out;

        vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 2'd0, 8'h00, 0};
        vecs[1] = '{8'h5A, 8'h5A, 8'h5B, 8'h5A, 1'b1, 2'd3, 8'h01, 1};
        vecs[2] = '{8'h01, 8'h02, 8'h00, 8'h00, 1'b1, 2'd0, 8'h03, 2};
        vecs[3] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 2'd2, 8'hFF, 3};
        vecs[4] = '{8'hF0, 8'h0F, 8'h0F, 8'h0F, 1'b1, 2'd1, 8'hFF, 4};
        vecs[5] = '{8'h12, 8'h34, 8'h12, 8'h12, 1'b1, 2'd2, 8'h26, 5};
        vecs[6] = '{8'h00, 8'h0F, 8'hF0, 8'h00, 1'b1, 2'd0, 8'hFF, 6};
        vecs[7] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 2'd0, 8'h00, 6};

        // Reset with all copies high
        rstn = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        a = 8'hFF; b = 8'hFF; c = 8'hFF;
        step(); step();
        check("rst_out", out, 0);
        check("rst_cnt", cnt, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_drop", drop, 0);
        rstn = 1'b1;
        step();
        check("rel_out", out, 8'hFF);
        check("rel_err", err, 0);

        // Vector table, consumer always ready
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
            step();
            check("tbl_out", out, vecs[i].exp_out);
            check("tbl_err", err, vecs[i].exp_err);
            check("tbl_cnt", cnt, vecs[i].exp_cnt);
            check("tbl_valid", valid, FIFO_EN && vecs[i].exp_err);
            check("tbl_data", data,
                  (FIFO_EN && vecs[i].exp_err) ? {vecs[i].exp_id, vecs[i].exp_mask} : 10'h0);
        end

        // Overflow: DEPTH+2 events with the consumer stalled
        evt_ready = 1'b0;
        for (int k = 0; k < D + 2; k++) begin
            a = 8'(k + 1); b = 8'h00; c = 8'h00;
            step();
        end
        check("ovf_drop", drop, FIFO_EN);
        check("ovf_cnt", cnt, 6 + D + 2);
        a = 8'h00; b = 8'h00; c = 8'h00;
        evt_ready = 1'b1;
        for (int k = 0; k < D; k++) begin
            check("drain_data", data, FIFO_EN ? {2'd1, 8'(k + 1)} : 10'h0);
            step();
        end
        check("drain_empty", valid, 0);

        // Full FIFO with simultaneous pop and push
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_drop", drop, 0);
        evt_ready = 1'b0;
        for (int k = 0; k < D; k++) begin
            a = 8'h10; b = 8'h10; c = 8'(8'h10 ^ (1 << k));
            step();
        end
        evt_ready = 1'b1;
        a = 8'h80; b = 8'h00; c = 8'h00;
        step();
        check("fullpp_drop", drop, 0);
        a = 8'h00;
        evt_ready = 1'b0;
        step();
        evt_ready = 1'b1;
        n_out = 0;
        for (int k = 0; k < 10 && valid; k++) begin
            n_out++;
            step();
        end
        check("fullpp_occ", n_out, FIFO_EN ? D : 0);

        // Saturation of the narrow counter
        clr = 1'b1; step(); clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            a = 8'h5A; b = 8'h5A; c = 8'(8'h5A ^ k[7:0] ^ 8'h80);
            step();
        end
        check("sat_cnt4", cnt4, 15);
        check("sat_cnt", cnt, 17);

        // clr alongside a mismatch: not counted, event still queued
        a = 8'h00; b = 8'h00; c = 8'h00;
        for (int k = 0; k < D + 1; k++) step();
        evt_ready = 1'b0;
        clr = 1'b1; a = 8'h5A; b = 8'h5A; c = 8'h5B;
        step();
        clr = 1'b0;
        check("clrmis_cnt", cnt, 0);
        check("clrmis_drop", drop, 0);
        check("clrmis_valid", valid, FIFO_EN);
        check("clrmis_data", data, FIFO_EN ? {2'd3, 8'h01} : 10'h0);
        for (int k = 0; k < D; k++) step();
        check("fill_drop", drop, FIFO_EN);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clrdrop_drop", drop, 0);

        // Reset while events are queued
        rstn = 1'b0; step(); rstn = 1'b1;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            base = 8'($urandom);
            a = base; b = base; c = base;
            case ($urandom_range(0, 3))
                0: a = a ^ 8'(1 << $urandom_range(0, 7));
                1: b = b ^ 8'(1 << $urandom_range(0, 7));
                2: c = c ^ 8'($urandom);
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            end
            evt_ready = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 30) == 0);
            rstn      = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
